// File: rtl/pipe_pkg.sv
// Shared defaults for the elastic pipeline register family.
// Holds the default data width, reset value and the occupancy-count width helper.
package pipe_pkg;

    localparam int          PIPE_WIDTH     = 32;
    localparam logic [31:0] PIPE_RESET_VAL = 32'h0000_0000;

    // Bits needed to hold 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pipe_data_stage.sv
// One valid/data slice of the elastic pipeline; 1-cycle register, loads on rdy.
// Holds v and d when rdy is low; flush clears v but keeps d.
module pipe_data_stage
    import pipe_pkg::*;
#(
    parameter int               WIDTH     = PIPE_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(PIPE_RESET_VAL)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             flush,
    input  logic             rdy,
    input  logic             prev_v,
    input  logic [WIDTH-1:0] prev_d,
    output logic             v,
    output logic [WIDTH-1:0] d
);

    always_ff @(posedge CLK) begin
        if (RST) begin
            v <= 1'b0;
            d <= RESET_VAL;
        end else if (flush) begin
            v <= 1'b0;
        end else if (rdy) begin
            v <= prev_v;
            // Data only moves with a real beat, so bubbles never toggle it.
            if (prev_v) begin
                d <= prev_d;
            end
        end
    end

endmodule

// File: rtl/pipe_data_reg.sv
// Elastic pipeline register: DEPTH stages, DEPTH-cycle fill latency, 1 beat/cycle.
// Combinational ready chain collapses bubbles; in_ready drops only when all stages are full and stalled.
module pipe_data_reg
    import pipe_pkg::*;
#(
    parameter int               WIDTH     = PIPE_WIDTH,
    parameter int               DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(PIPE_RESET_VAL),
    parameter int               CNT_W     = cnt_width(DEPTH)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] count
);

    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] rdy;
    logic [WIDTH-1:0] d [DEPTH];
    logic             in_xfer;
    logic             out_xfer;

    // Walk from the head back toward the input so each stage sees its successor's ready.
    always_comb begin
        rdy            = '0;
        rdy[DEPTH-1]   = ~v[DEPTH-1] | out_ready;
        for (int k = DEPTH - 2; k >= 0; k--) begin
            rdy[k] = ~v[k] | rdy[k+1];
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic             pv;
        logic [WIDTH-1:0] pd;

        if (k == 0) begin : g_first
            assign pv = in_valid;
            assign pd = in_data;
        end else begin : g_next
            assign pv = v[k-1];
            assign pd = d[k-1];
        end

        pipe_data_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .CLK    (CLK),
            .RST    (RST),
            .flush  (flush),
            .rdy    (rdy[k]),
            .prev_v (pv),
            .prev_d (pd),
            .v      (v[k]),
            .d      (d[k])
        );
    end

    assign in_ready  = rdy[0] & ~flush;
    assign out_valid = v[DEPTH-1] & ~flush;
    assign out_data  = d[DEPTH-1];

    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = out_valid & out_ready;

    always_ff @(posedge CLK) begin
        if (RST || flush) begin
            count <= '0;
        end else if (in_xfer && !out_xfer) begin
            count <= count + CNT_W'(1);
        end else if (out_xfer && !in_xfer) begin
            count <= count - CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_data_reg.sv
// Bench for pipe_data_reg (DEPTH=3): directed plan followed by random traffic against a beat-queue model.
module tb_pipe_data_reg;

    localparam int          WIDTH     = 32;
    localparam int          DEPTH     = 3;
    localparam int          CNT_W     = $clog2(DEPTH + 1);
    localparam logic [31:0] RESET_VAL = 32'hDEAD_BEEF;

    logic             CLK;
    logic             RST;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [CNT_W-1:0] count;

    pipe_data_reg #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .RESET_VAL (RESET_VAL),
        .CNT_W     (CNT_W)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Model: ordered beats, each with its stage position (DEPTH-1 is the head).
    typedef struct {
        logic [31:0] dat;
        int          pos;
    } beat_t;

    beat_t       q[$];
    logic [31:0] last_out;
    logic [31:0] rx[$];
    logic        exp_ir;
    logic        exp_ov;
    logic        pend;
    logic [31:0] pend_dat;
    int          errors;
    int          checks;
    int          max_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic r, input logic f, input logic iv,
                         input logic [31:0] id, input logic ordy);
        @(negedge CLK);
        if (pend && !r && !f) begin
            checks++;
            assert (iv === 1'b1 && id === pend_dat) else begin
                errors++;
                $error("FAIL hold_input: observed valid=%0b data=%h expected valid=1 data=%h",
                       iv, id, pend_dat);
            end
        end
        RST       = r;
        flush     = f;
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        #1;
        exp_ir = !f && (q.size() < DEPTH || ordy);
        exp_ov = !f && q.size() > 0 && q[0].pos == DEPTH - 1;
        chk("in_ready",  32'(in_ready),  32'(exp_ir));
        chk("out_valid", 32'(out_valid), 32'(exp_ov));
        chk("count",     32'(count),     32'(q.size()));
        chk("out_data",  out_data,       last_out);
        if (out_valid && out_ready) rx.push_back(out_data);
        if (int'(count) > max_cnt) max_cnt = int'(count);
    endtask

    task automatic tick();
        int lim;
        @(posedge CLK);
        if (RST || flush) begin
            q.delete();
            if (RST) last_out = RESET_VAL;
        end else begin
            if (exp_ov && out_ready) void'(q.pop_front());
            if (exp_ir && in_valid) q.push_back('{dat: in_data, pos: -1});
            // Every beat advances one stage unless the beat ahead blocks it.
            lim = DEPTH - 1;
            for (int i = 0; i < q.size(); i++) begin
                if (q[i].pos + 1 < lim) q[i].pos = q[i].pos + 1;
                else                    q[i].pos = lim;
                lim = q[i].pos - 1;
            end
            if (q.size() > 0 && q[0].pos == DEPTH - 1) last_out = q[0].dat;
        end
        pend     = in_valid && !exp_ir && !RST && !flush;
        pend_dat = in_data;
    endtask

    task automatic cyc(input logic r, input logic f, input logic iv,
                       input logic [31:0] id, input logic ordy);
        drive(r, f, iv, id, ordy);
        tick();
    endtask

    task automatic chk_seq(input string tag, input logic [31:0] first, input int n);
        chk({tag, "_len"}, 32'(rx.size()), 32'(n));
        for (int i = 0; i < n && i < rx.size(); i++) begin
            chk({tag, "_beat"}, rx[i], first + 32'(i));
        end
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        max_cnt   = 0;
        pend      = 1'b0;
        pend_dat  = '0;
        RST       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        @(posedge CLK);
        q.delete();
        last_out = RESET_VAL;

        // Reset then idle
        drive(0, 0, 0, 0, 1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  out_data,       32'hDEAD_BEEF);
        chk("rst_count",     32'(count),     32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        tick();

        // Streaming 1..4
        rx.delete();
        max_cnt = 0;
        for (int i = 1; i <= 4; i++) cyc(0, 0, 1, 32'(i), 1);
        for (int i = 0; i < 4; i++)  cyc(0, 0, 0, 0, 1);
        chk_seq("stream", 32'd1, 4);
        chk("stream_peak", 32'(max_cnt), 32'd3);

        // Back-pressure: 5,6,7 fill, 8 offered while full
        rx.delete();
        for (int i = 5; i <= 7; i++) cyc(0, 0, 1, 32'(i), 0);
        drive(0, 0, 1, 32'd8, 0);
        chk("bp_count",    32'(count),    32'd3);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        tick();
        cyc(0, 0, 1, 32'd8, 1);
        for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 1);
        chk_seq("bp", 32'd5, 4);

        // Bubble collapse: 9, two idles, 10, stalled
        rx.delete();
        cyc(0, 0, 1, 32'd9, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 1, 32'd10, 0);
        cyc(0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1);
        chk("bub_count", 32'(count), 32'd2);
        chk("bub_head",  out_data,   32'd9);
        tick();
        drive(0, 0, 0, 0, 1);
        chk("bub_next_valid", 32'(out_valid), 32'd1);
        chk("bub_next_data",  out_data,       32'd10);
        tick();

        // Flush with 3 stored beats and a coincident input
        rx.delete();
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 32'h20 + 32'(i), 0);
        drive(0, 1, 1, 32'd11, 1);
        chk("fl_in_ready",  32'(in_ready),  32'd0);
        chk("fl_out_valid", 32'(out_valid), 32'd0);
        tick();
        drive(0, 0, 1, 32'd12, 1);
        chk("fl_count_after", 32'(count),     32'd0);
        chk("fl_valid_after", 32'(out_valid), 32'd0);
        tick();
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 1);
        chk_seq("fl", 32'd12, 1);

        // Reset mid-stream, then reset together with flush
        for (int pass = 0; pass < 2; pass++) begin
            cyc(0, 0, 1, 32'h30, 0);
            cyc(0, 0, 1, 32'h31, 0);
            cyc(1, pass[0], 0, 0, 1);
            drive(0, 0, 0, 0, 1);
            chk("mrst_count",     32'(count),     32'd0);
            chk("mrst_out_valid", 32'(out_valid), 32'd0);
            chk("mrst_out_data",  out_data,       32'hDEAD_BEEF);
            tick();
        end

        // Random traffic
        for (int c = 0; c < 600; c++) begin
            logic        r;
            logic        f;
            logic        iv;
            logic        ordy;
            logic [31:0] id;
            r    = ($urandom_range(63) == 0);
            f    = ($urandom_range(23) == 0);
            ordy = ($urandom_range(9) < 6);
            if (pend) begin
                iv = 1'b1;
                id = pend_dat;
            end else begin
                iv = ($urandom_range(9) < 7);
                id = $urandom;
            end
            cyc(r, f, iv, id, ordy);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
